servo_slew: RTL and testbench

//  Upstream feeder for the servo PWM generator: accepts target positions over a valid/ready

---
 rtl/servo_pkg.sv | 37 +++
 rtl/servo_frame_tick.sv | 28 ++
 rtl/servo_slew.sv | 91 +++++++++
 tb/tb_servo_slew.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared types, widths and position helpers for the servo slew limiter
// and the planned multi-channel sequencer.
package servo_pkg;

  localparam int POS_W = 8;
  localparam int SPD_W = 4;

  typedef enum logic {
    S_IDLE,
    S_MOVE
  } state_t;

  // Limit a requested position to the mechanical travel window [lo, hi].
  function automatic logic [POS_W-1:0] clamp_pos(
    input logic [POS_W-1:0] pos,
    input logic [POS_W-1:0] lo,
    input logic [POS_W-1:0] hi
  );
    logic [POS_W-1:0] res;
    res = pos;
    if (pos < lo) res = lo;
    if (pos > hi) res = hi;
    return res;
  endfunction

  // Step actually taken this frame: the programmed speed, shortened so the
  // final step lands exactly on the target instead of overshooting it.
  function automatic logic [POS_W-1:0] step_size(
    input logic [SPD_W-1:0] spd,
    input logic [POS_W-1:0] mag
  );
    logic [POS_W-1:0] spd_ext;
    spd_ext = {{(POS_W-SPD_W){1'b0}}, spd};
    return (mag < spd_ext) ? mag : spd_ext;
  endfunction

endpackage

// File: rtl/servo_frame_tick.sv
// Free-running frame counter with a registered one-cycle pulse per wrap.
// Ticks are exactly 2^PERIOD_BITS clocks apart; the PWM stage can share it
// to keep its frames phase-aligned with position updates.
module servo_frame_tick #(
  parameter int PERIOD_BITS = 20
) (
  input  logic clk,
  input  logic rst,
  output logic frame_tick
);

  logic [PERIOD_BITS-1:0] cnt_reg;
  logic                   tick_reg;

  // Counter wraps naturally; the pulse follows the all-ones count by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_reg + 1'b1;
      tick_reg <= (cnt_reg == {PERIOD_BITS{1'b1}});
    end
  end

  assign frame_tick = tick_reg;

endmodule

// File: rtl/servo_slew.sv
// Slew-rate limiter between the command source and the servo PWM stage.
// Accepts a target and step size, then walks 'val' toward the target by at
// most one step per PWM frame. Speed 0 (or an already-reached target) jumps.
module servo_slew
  import servo_pkg::*;
#(
  parameter int               PERIOD_BITS = 20,
  parameter logic [POS_W-1:0] INIT_POS    = 8'd128,
  parameter logic [POS_W-1:0] MIN_POS     = 8'd0,
  parameter logic [POS_W-1:0] MAX_POS     = 8'd255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [POS_W-1:0] tgt_pos,
  input  logic [SPD_W-1:0] tgt_speed,
  output logic [POS_W-1:0] val,
  output logic             busy,
  output logic             frame_tick
);

  state_t           state_reg;
  logic [POS_W-1:0] val_reg;
  logic [POS_W-1:0] tgt_reg;
  logic [SPD_W-1:0] spd_reg;

  logic [POS_W-1:0] tgt_clamped;
  logic signed [POS_W:0] diff;
  logic [POS_W-1:0] mag;
  logic [POS_W-1:0] step;
  logic [POS_W-1:0] next_pos;
  logic             step_done;

  servo_frame_tick #(
    .PERIOD_BITS(PERIOD_BITS)
  ) u_frame_tick (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick)
  );

  assign tgt_clamped = clamp_pos(tgt_pos, MIN_POS, MAX_POS);

  // Step datapath: signed distance to target, its magnitude, and the
  // clipped step. Magnitude never exceeds 255 so the low byte suffices.
  always_comb begin
    diff      = $signed({1'b0, tgt_reg}) - $signed({1'b0, val_reg});
    mag       = diff[POS_W] ? (~diff[POS_W-1:0] + 1'b1) : diff[POS_W-1:0];
    step      = step_size(spd_reg, mag);
    next_pos  = diff[POS_W] ? (val_reg - step) : (val_reg + step);
    step_done = (step == mag);
  end

  // Control FSM plus target/speed/position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      val_reg   <= INIT_POS;
      tgt_reg   <= INIT_POS;
      spd_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (tgt_valid) begin
            tgt_reg <= tgt_clamped;
            spd_reg <= tgt_speed;
            if (tgt_speed == '0 || tgt_clamped == val_reg) begin
              val_reg <= tgt_clamped;
            end else begin
              state_reg <= S_MOVE;
            end
          end
        end
        S_MOVE: begin
          if (frame_tick) begin
            val_reg <= next_pos;
            if (step_done) state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Handshake/status decode straight from state; no path from tgt_valid.
  assign tgt_ready = (state_reg == S_IDLE);
  assign busy      = (state_reg == S_MOVE);
  assign val       = val_reg;

endmodule

// File: tb/tb_servo_slew.sv
// Self-checking bench for servo_slew with 16-clock frames. A behavioural
// model (integer positions, frame ticks from clock-count modulo) predicts
// every output each cycle; directed steps cover reset, jump, ramps, clamp,
// backpressure and reset mid-ramp, followed by random transactions.
module tb_servo_slew;

  localparam int FRAME = 16;
  localparam int LO    = 20;
  localparam int HI    = 240;
  localparam int INIT  = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tgt_valid = 1'b0;
  logic       tgt_ready;
  logic [7:0] tgt_pos = 8'd0;
  logic [3:0] tgt_speed = 4'd0;
  logic [7:0] val;
  logic       busy;
  logic       frame_tick;

  always #5 clk = ~clk;

  servo_slew #(
    .PERIOD_BITS(4),
    .INIT_POS   (8'd128),
    .MIN_POS    (8'd20),
    .MAX_POS    (8'd240)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_pos   (tgt_pos),
    .tgt_speed (tgt_speed),
    .val       (val),
    .busy      (busy),
    .frame_tick(frame_tick)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_val = INIT;
  int m_tgt = INIT;
  int m_spd = 0;
  int edges = 0;
  bit m_busy = 1'b0;
  bit m_tick = 1'b0;
  int txn = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock, update the model from pre-edge inputs, compare outputs.
  task automatic tick_clk();
    bit tick_pre;
    int d, mv, t;
    tick_pre = m_tick;
    @(posedge clk);
    if (rst) begin
      m_val  = INIT;
      m_busy = 1'b0;
      edges  = 0;
      m_tick = 1'b0;
    end else begin
      edges++;
      if (m_busy) begin
        if (tick_pre) begin
          d  = m_tgt - m_val;
          mv = (d < 0) ? -d : d;
          if (mv > m_spd) mv = m_spd;
          m_val = (d < 0) ? m_val - mv : m_val + mv;
          if (m_val == m_tgt) m_busy = 1'b0;
        end
      end else if (tgt_valid) begin
        t = int'(tgt_pos);
        if (t < LO) t = LO;
        if (t > HI) t = HI;
        if (tgt_speed == 4'd0 || t == m_val) begin
          m_val = t;
        end else begin
          m_busy = 1'b1;
          m_tgt  = t;
          m_spd  = int'(tgt_speed);
        end
      end
      m_tick = (edges % FRAME == 0);
    end
    #1;
    check("val", {24'd0, val}, m_val);
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("ready", {31'd0, tgt_ready}, {31'd0, !m_busy});
    check("tick", {31'd0, frame_tick}, {31'd0, m_tick});
  endtask

  // Offer a target and hold it until the block accepts it.
  task automatic send(input int pos, input int spd);
    bit ok, acc;
    ok = 1'b0;
    tgt_valid = 1'b1;
    tgt_pos   = 8'(pos);
    tgt_speed = 4'(spd);
    for (int i = 0; i < 6000 && !ok; i++) begin
      acc = !m_busy;
      tick_clk();
      ok = acc;
    end
    tgt_valid = 1'b0;
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL accept_timeout observed %0d expected 1", ok);
    end
    txn++;
    $display("txn %0d pos %0d spd %0d -> val %0d busy %0d", txn, pos, spd, val, busy);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy && n < 6000) begin
      tick_clk();
      n++;
    end
    checks++;
    assert (!m_busy) else begin
      errors++;
      $error("FAIL idle_timeout observed busy %0d expected 0", m_busy);
    end
  endtask

  initial begin
    int seq[$];
    int prev, n;

    // 1. Reset held three cycles, first tick 16 clocks later
    rst = 1'b1;
    repeat (3) tick_clk();
    check("reset_val", {24'd0, val}, 128);
    rst = 1'b0;
    repeat (FRAME - 1) tick_clk();
    check("no_early_tick", {31'd0, frame_tick}, 0);
    tick_clk();
    check("first_tick", {31'd0, frame_tick}, 1);

    // 2. Jump
    send(200, 0);
    check("jump_val", {24'd0, val}, 200);
    send(128, 0);

    // 3. Ramp up 128 -> 140 at speed 5
    send(140, 5);
    prev = 128;
    n = 0;
    while (m_busy && n < 200) begin
      tick_clk();
      if (int'(val) != prev) begin
        seq.push_back(int'(val));
        prev = int'(val);
      end
      n++;
    end
    check("ramp_steps", seq.size(), 3);
    if (seq.size() == 3) begin
      check("ramp_s0", seq[0], 133);
      check("ramp_s1", seq[1], 138);
      check("ramp_s2", seq[2], 140);
    end
    tick_clk();
    check("ramp_busy_low", {31'd0, busy}, 0);

    // 4. Ramp down with clamp to MIN_POS
    send(30, 0);
    send(5, 15);
    wait_idle();
    check("clamp_val", {24'd0, val}, 20);

    // 5. Backpressure: a second request during MOVE waits for IDLE
    send(100, 3);
    send(60, 0);
    check("bp_val", {24'd0, val}, 60);
    n = 0;
    while (!m_tick && n < 2 * FRAME) begin
      tick_clk();
      n++;
    end
    send(90, 7);
    check("coinc_hold", {24'd0, val}, 60);
    check("coinc_busy", {31'd0, busy}, 1);
    repeat (FRAME) tick_clk();
    check("coinc_first_step", {24'd0, val}, 67);
    wait_idle();
    check("coinc_final", {24'd0, val}, 90);

    // 6. Reset mid-ramp at val 60
    send(50, 2);
    n = 0;
    while (m_val != 60 && n < 1000) begin
      tick_clk();
      n++;
    end
    check("pre_reset_val", {24'd0, val}, 60);
    rst = 1'b1;
    tick_clk();
    check("rst_val", {24'd0, val}, 128);
    check("rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;

    // Random targets, speeds (including jumps) and idle gaps
    for (int k = 0; k < 25; k++) begin
      int sp;
      sp = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(2, 15));
      send(int'($urandom_range(0, 255)), sp);
      repeat ($urandom_range(0, 20)) tick_clk();
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
